// File: rtl/motion_cmd_scheduler_pkg.sv
// Shared types and default timing constants for the motion command scheduler.
// Build option: MOTION_HEARTBEAT_EN enables the periodic resend of the last command.
package motion_cmd_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned SPEED_W = 3;
  localparam int unsigned CMD_W   = OP_W + SPEED_W;

  typedef enum logic [OP_W-1:0] {
    OP_STOP  = 2'd0,
    OP_FWD   = 2'd1,
    OP_LEFT  = 2'd2,
    OP_RIGHT = 2'd3
  } op_e;

  typedef struct packed {
    op_e                op;
    logic [SPEED_W-1:0] speed;
  } motion_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } sched_state_e;

  // Defaults assume a 50 MHz clock.
  localparam int unsigned DEF_NUM_REQ        = 3;
  localparam int unsigned DEF_GAP_CYCLES     = 50_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 15_000_000;
  localparam int unsigned DEF_HB_CYCLES      = 5_000_000;

  // Counter width for a count range of 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/motion_cmd_scheduler_if.sv
// Requester / sender handshake bundle for the motion command scheduler.
// master = control-logic and UART-sender side, slave = the scheduler.
interface motion_cmd_scheduler_if
  import motion_cmd_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     tx_start;
  logic [OP_W-1:0]          tx_op;
  logic [SPEED_W-1:0]       tx_speed;
  logic                     tx_done;
  logic                     busy;
  logic                     tx_timeout;

  modport master (
    output req_valid, req_cmd, tx_done,
    input  req_ack, tx_start, tx_op, tx_speed, busy, tx_timeout
  );

  modport slave (
    input  req_valid, req_cmd, tx_done,
    output req_ack, tx_start, tx_op, tx_speed, busy, tx_timeout
  );

endinterface

// File: rtl/motion_cmd_scheduler_arbiter.sv
// Combinational fixed-priority arbiter: lowest set request index wins.
module fixed_prio_arbiter
  import motion_cmd_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_any_c
);

  // Scan from the top down so the lowest active index is written last.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant_c    = '0;
        o_grant_c[i] = 1'b1;
        o_idx_c      = IDX_W'(i);
        o_any_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/motion_cmd_scheduler.sv
// Arbitrates motion requesters onto the single UART command sender with dedup, gap and timeout.
// Build option: MOTION_HEARTBEAT_EN adds the periodic resend of the last non-STOP command.
module motion_cmd_scheduler
  import motion_cmd_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned HB_CYCLES      = DEF_HB_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  motion_cmd_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = cnt_width(NUM_REQ);
  localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);

  if (GAP_CYCLES == 0 || TIMEOUT_CYCLES == 0 || HB_CYCLES == 0) begin : g_param_check
    $error("motion_cmd_scheduler: cycle parameters must be nonzero");
  end

  sched_state_e       r_state, w_state_nxt;
  motion_cmd_t        r_last, w_last_nxt;
  motion_cmd_t        r_tx_cmd, w_tx_cmd_nxt;
  logic [NUM_REQ-1:0] r_req_ack, w_req_ack_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic               r_busy;
  logic               r_tx_timeout, w_tx_timeout_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [TO_W-1:0]    r_to_cnt, w_to_cnt_nxt;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  motion_cmd_t        w_req_cmd;

  fixed_prio_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req     (bus.req_valid),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  assign w_req_cmd = motion_cmd_t'(bus.req_cmd[32'(w_idx) * CMD_W +: CMD_W]);

`ifdef MOTION_HEARTBEAT_EN
  localparam int unsigned HB_W = cnt_width(HB_CYCLES);

  logic [HB_W-1:0] r_hb_cnt;
  logic            w_hb_expired;

  assign w_hb_expired = (r_hb_cnt == HB_W'(HB_CYCLES - 1));

  // Saturating age counter, restarted by every frame start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hb_cnt <= '0;
    end else if (w_tx_start_nxt) begin
      r_hb_cnt <= '0;
    end else if (!w_hb_expired) begin
      r_hb_cnt <= r_hb_cnt + HB_W'(1);
    end
  end
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last       <= '{op: OP_STOP, speed: '0};
      r_tx_cmd     <= '{op: OP_STOP, speed: '0};
      r_req_ack    <= '0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_timeout <= 1'b0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last       <= w_last_nxt;
      r_tx_cmd     <= w_tx_cmd_nxt;
      r_req_ack    <= w_req_ack_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_tx_timeout <= w_tx_timeout_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last;
    w_tx_cmd_nxt     = r_tx_cmd;
    w_req_ack_nxt    = '0;
    w_tx_start_nxt   = 1'b0;
    w_tx_timeout_nxt = r_tx_timeout;
    w_gap_cnt_nxt    = '0;
    w_to_cnt_nxt     = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_ack_nxt = w_grant;
          // A repeat of the last delivered command is acknowledged but not resent.
          if (w_req_cmd != r_last) begin
            w_state_nxt    = ST_ISSUE;
            w_tx_start_nxt = 1'b1;
            w_tx_cmd_nxt   = w_req_cmd;
          end
        end
`ifdef MOTION_HEARTBEAT_EN
        else if (w_hb_expired && (r_last.op != OP_STOP)) begin
          w_state_nxt    = ST_ISSUE;
          w_tx_start_nxt = 1'b1;
          w_tx_cmd_nxt   = r_last;
        end
`endif
      end

      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (bus.tx_done) begin
          w_last_nxt  = r_tx_cmd;
          w_state_nxt = ST_GAP;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_tx_timeout_nxt = 1'b1;
          w_state_nxt      = ST_GAP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ack    = r_req_ack;
  assign bus.tx_start   = r_tx_start;
  assign bus.tx_op      = r_tx_cmd.op;
  assign bus.tx_speed   = r_tx_cmd.speed;
  assign bus.busy       = r_busy;
  assign bus.tx_timeout = r_tx_timeout;

endmodule

// File: tb/tb_motion_cmd_scheduler.sv
// Directed bench for motion_cmd_scheduler with a frame scoreboard (GAP=4, TIMEOUT=100, HB=50).
module tb_motion_cmd_scheduler;
  import motion_cmd_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned GAP  = 4;
  localparam int unsigned TO   = 100;
  localparam int unsigned HB   = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;

  motion_cmd_scheduler_if #(.NUM_REQ(NREQ)) bus ();

  motion_cmd_scheduler #(
    .NUM_REQ        (NREQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .HB_CYCLES      (HB)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_starts = 0;
  int unsigned cyc_now = 0;
  int unsigned last_start = 0;
  logic [4:0]  sb[$];

  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Every frame start must match the oldest expected command.
  always @(negedge clk) begin : mon
    logic [4:0] e;
    if (bus.tx_start) begin
      n_starts++;
      last_start = cyc_now;
      chk("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_cmd", 32'({bus.tx_op, bus.tx_speed}), 32'(e));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cmd(input int idx, input logic [1:0] op, input logic [2:0] spd);
    bus.req_cmd[idx*5 +: 5] = {op, spd};
  endtask

  task automatic done_pulse();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int c;
    c = 0;
    while (!bus.tx_start && c < 300) begin
      tick();
      c++;
    end
    chk(tag, 32'(bus.tx_start), 32'd1);
  endtask

  initial begin
    int cyc;
    int p;
    int unsigned t0;
    bus.req_valid = '0;
    bus.req_cmd   = '0;
    bus.tx_done   = 1'b0;
    rst = 1'b0;
    tick(3);
    chk("rst_ack",     32'(bus.req_ack),    32'd0);
    chk("rst_start",   32'(bus.tx_start),   32'd0);
    chk("rst_busy",    32'(bus.busy),       32'd0);
    chk("rst_timeout", 32'(bus.tx_timeout), 32'd0);
    chk("rst_op",      32'(bus.tx_op),      32'd0);
    chk("rst_speed",   32'(bus.tx_speed),   32'd0);
    rst = 1'b1;
    tick();

    // Single request; a tx_done during ISSUE must be ignored
    set_cmd(1, OP_FWD, 3'd1);
    bus.req_valid = 3'b010;
    sb.push_back({OP_FWD, 3'd1});
    tick();
    chk("t1_ack",   32'(bus.req_ack),  32'b010);
    chk("t1_start", 32'(bus.tx_start), 32'd1);
    chk("t1_op",    32'(bus.tx_op),    32'd1);
    chk("t1_speed", 32'(bus.tx_speed), 32'd1);
    chk("t1_busy",  32'(bus.busy),     32'd1);
    bus.req_valid = '0;
    bus.tx_done   = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t1_start_pulse", 32'(bus.tx_start), 32'd0);
    chk("t1_ack_pulse",   32'(bus.req_ack),  32'd0);
    tick(3);
    chk("t1_still_wait", 32'(bus.busy),  32'd1);
    chk("t1_op_stable",  32'(bus.tx_op), 32'd1);
    done_pulse();
    chk("t1_gap_first", 32'(bus.busy), 32'd1);
    tick(3);
    chk("t1_gap_last", 32'(bus.busy), 32'd1);
    tick();
    chk("t1_idle", 32'(bus.busy), 32'd0);

    // Two requesters: index 1 first, index 2 granted GAP+2 cycles after tx_done
    set_cmd(1, OP_LEFT, 3'd2);
    set_cmd(2, OP_RIGHT, 3'd5);
    bus.req_valid = 3'b110;
    sb.push_back({OP_LEFT, 3'd2});
    sb.push_back({OP_RIGHT, 3'd5});
    tick();
    chk("t2_ack_first", 32'(bus.req_ack),  32'b010);
    chk("t2_start1",    32'(bus.tx_start), 32'd1);
    bus.req_valid = 3'b100;
    tick();
    done_pulse();
    cyc = 1;
    while (bus.req_ack == '0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("t2_ack_latency", 32'(cyc),          32'd6);
    chk("t2_ack_second",  32'(bus.req_ack),  32'b100);
    chk("t2_start2",      32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    tick();
    done_pulse();
    tick(4);

    // Duplicate of the last delivered command: ack only
    set_cmd(0, OP_RIGHT, 3'd5);
    bus.req_valid = 3'b001;
    tick();
    chk("t3_ack",      32'(bus.req_ack),  32'b001);
    chk("t3_no_start", 32'(bus.tx_start), 32'd0);
    chk("t3_busy",     32'(bus.busy),     32'd0);
    bus.req_valid = '0;
    tick(2);
    chk("t3_idle", 32'(bus.busy), 32'd0);

    // tx_done in the expiry cycle wins over the timeout
    set_cmd(0, OP_STOP, 3'd2);
    bus.req_valid = 3'b001;
    sb.push_back({OP_STOP, 3'd2});
    tick();
    chk("t4a_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    tick(TO);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    chk("t4a_no_timeout", 32'(bus.tx_timeout), 32'd0);
    chk("t4a_gap",        32'(bus.busy),       32'd1);
    tick(4);
    chk("t4a_idle", 32'(bus.busy), 32'd0);

    // Timeout: sticky flag, last command left unchanged
    set_cmd(2, OP_FWD, 3'd3);
    bus.req_valid = 3'b100;
    sb.push_back({OP_FWD, 3'd3});
    tick();
    chk("t4_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    cyc = 0;
    while (!bus.tx_timeout && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("t4_timeout_latency", 32'(cyc),            32'd101);
    chk("t4_timeout",         32'(bus.tx_timeout), 32'd1);
    chk("t4_gap",             32'(bus.busy),       32'd1);
    tick(3);
    chk("t4_gap_last", 32'(bus.busy), 32'd1);
    tick();
    chk("t4_idle", 32'(bus.busy), 32'd0);
    bus.req_valid = 3'b100;
    sb.push_back({OP_FWD, 3'd3});
    tick();
    chk("t4_resend_ack",   32'(bus.req_ack),  32'b100);
    chk("t4_resend_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    tick();
    done_pulse();
    chk("t4_sticky", 32'(bus.tx_timeout), 32'd1);
    tick(4);

    // Heartbeat behaviour after {LEFT,3}
    set_cmd(1, OP_LEFT, 3'd3);
    bus.req_valid = 3'b010;
    sb.push_back({OP_LEFT, 3'd3});
    tick();
    chk("t5_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    tick();
    done_pulse();
    tick(4);
`ifdef MOTION_HEARTBEAT_EN
    for (int k = 0; k < 3; k++) begin
      t0 = last_start;
      sb.push_back({OP_LEFT, 3'd3});
      wait_start("t5_hb_start");
      chk("t5_hb_period", 32'(cyc_now - t0), 32'(HB));
      chk("t5_hb_no_ack", 32'(bus.req_ack),  32'd0);
      tick();
      done_pulse();
      tick(4);
    end
    set_cmd(0, OP_STOP, 3'd0);
    bus.req_valid = 3'b001;
    sb.push_back({OP_STOP, 3'd0});
    tick();
    chk("t5_stop_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    tick();
    done_pulse();
    p = n_starts;
    tick(150);
    chk("t5_no_hb_after_stop", 32'(n_starts - p), 32'd0);
`else
    p = n_starts;
    tick(150);
    chk("t5_no_hb_default", 32'(n_starts - p), 32'd0);
`endif

    // Index-0 STOP wins arbitration; then reset in WAIT_DONE
    set_cmd(0, OP_STOP, 3'd1);
    set_cmd(1, OP_FWD, 3'd2);
    bus.req_valid = 3'b011;
    sb.push_back({OP_STOP, 3'd1});
    tick();
    chk("t6_ack",   32'(bus.req_ack),  32'b001);
    chk("t6_start", 32'(bus.tx_start), 32'd1);
    bus.req_valid = '0;
    tick();
    chk("t6_wait_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    tick();
    chk("t6_rst_ack",     32'(bus.req_ack),    32'd0);
    chk("t6_rst_start",   32'(bus.tx_start),   32'd0);
    chk("t6_rst_busy",    32'(bus.busy),       32'd0);
    chk("t6_rst_op",      32'(bus.tx_op),      32'd0);
    chk("t6_rst_speed",   32'(bus.tx_speed),   32'd0);
    chk("t6_rst_timeout", 32'(bus.tx_timeout), 32'd0);
    rst = 1'b1;
    tick();

    // After reset the last command is {STOP,0}, so it is a duplicate
    set_cmd(2, OP_STOP, 3'd0);
    bus.req_valid = 3'b100;
    tick();
    chk("t7_dup_ack",      32'(bus.req_ack),  32'b100);
    chk("t7_dup_no_start", 32'(bus.tx_start), 32'd0);
    bus.req_valid = '0;
    tick(3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
